// File: rtl/qam_demapper_pkg.sv
// Shared definitions for the QAM hard-decision demapper read-out path.
package qam_demapper_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/qam_readout_arbiter_rr.sv
// Combinational round-robin pick: first requester at index >= rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_HOSTS = 4
) (
    input  logic [NUM_HOSTS-1:0]         req,
    input  logic [$clog2(NUM_HOSTS)-1:0] rr_ptr,
    output logic [NUM_HOSTS-1:0]         grant,
    output logic [$clog2(NUM_HOSTS)-1:0] grant_idx,
    output logic                         any
);

    localparam int PTR_W = $clog2(NUM_HOSTS);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    logic [PTR_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_HOSTS)) begin
                cand = cand - (PTR_W+1)'(NUM_HOSTS);
            end
            if (!any && req[cand[PTR_W-1:0]]) begin
                any                     = 1'b1;
                grant_idx               = cand[PTR_W-1:0];
                grant[cand[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qam_readout_arbiter.sv
// Round-robin arbiter sharing the demapper FIFO read-out between host requesters.
//
// state   | meaning
// IDLE    | no grant; waiting for data (available or pending) and a requester
// GRANT   | grant registered; pulse dm_read unless the controller is already in read-out
// DRAIN   | pop FIFO words to the granted host until empty, burst limit or request drop
// RELEASE | host_done to the granted host; advance rr_ptr, record pending, drop grant
module qam_readout_arbiter
    import qam_demapper_pkg::*;
#(
    parameter int NUM_HOSTS = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = 16
) (
    input  logic                 dclk,
    input  logic                 reset,
    input  logic [NUM_HOSTS-1:0] host_req,
    output logic [NUM_HOSTS-1:0] host_grant,
    output logic                 host_valid,
    output logic [DATA_W-1:0]    host_data,
    output logic [NUM_HOSTS-1:0] host_done,
    input  logic                 dm_enable,
    input  logic                 dm_available,
    output logic                 dm_read,
    input  logic                 fifo_rdempty,
    input  logic [DATA_W-1:0]    fifo_rdata,
    output logic                 fifo_rinc,
    output logic                 abort
);

    localparam int PTR_W = $clog2(NUM_HOSTS);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] LAST_HOST = PTR_W'(NUM_HOSTS - 1);

    arb_state_t           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 pending;
    logic [CNT_W-1:0]     burst_cnt;

    logic [NUM_HOSTS-1:0] pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 granted_req;
    logic                 pop;
    logic                 drain_end;
    logic [PTR_W-1:0]     ptr_after;

    rr_arbiter #(
        .NUM_HOSTS (NUM_HOSTS)
    ) u_rr_arbiter (
        .req       (host_req),
        .rr_ptr    (rr_ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign granted_req = host_req[grant_idx];

    // The pop strobe must follow fifo_rdempty in the same cycle, so it is
    // decoded from the state rather than registered; reset and a falling
    // dm_enable block it immediately so nothing is lost from the FIFO.
    assign pop       = (state == DRAIN) & dm_enable & ~reset & ~fifo_rdempty & granted_req;
    assign fifo_rinc = pop;

    assign drain_end = fifo_rdempty | ~granted_req | (pop & (burst_cnt == LAST_CNT));
    assign ptr_after = (grant_idx == LAST_HOST) ? '0 : grant_idx + PTR_W'(1);

    always_ff @(posedge dclk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            pending    <= 1'b0;
            burst_cnt  <= '0;
            host_grant <= '0;
            host_valid <= 1'b0;
            host_data  <= '0;
            host_done  <= '0;
            dm_read    <= 1'b0;
            abort      <= 1'b0;
        end else begin
            host_valid <= 1'b0;
            host_done  <= '0;
            dm_read    <= 1'b0;
            abort      <= 1'b0;
            if (!dm_enable) begin
                // rr_ptr is kept (and advanced on abort) so the aborted host loses its turn.
                state      <= IDLE;
                pending    <= 1'b0;
                burst_cnt  <= '0;
                host_grant <= '0;
                if (state != IDLE) begin
                    abort  <= 1'b1;
                    rr_ptr <= ptr_after;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if ((dm_available | pending) & pick_any) begin
                            host_grant <= pick_onehot;
                            grant_idx  <= pick_idx;
                            dm_read    <= ~pending;
                            state      <= GRANT;
                        end
                    end
                    GRANT: begin
                        state <= DRAIN;
                    end
                    DRAIN: begin
                        if (pop) begin
                            host_data  <= fifo_rdata;
                            host_valid <= 1'b1;
                            burst_cnt  <= burst_cnt + CNT_W'(1);
                        end
                        if (drain_end) begin
                            host_done <= host_grant;
                            state     <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        host_grant <= '0;
                        burst_cnt  <= '0;
                        rr_ptr     <= ptr_after;
                        pending    <= ~fifo_rdempty;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qam_readout_arbiter.sv
// Scenario bench for qam_readout_arbiter: FIFO model, expected-word scoreboard, event counters.
module tb_qam_readout_arbiter;

    localparam int NH = 4;
    localparam int DW = 4;
    localparam int BM = 16;

    typedef struct packed {
        logic [NH-1:0] grant;
        logic [DW-1:0] data;
    } sb_t;

    logic          dclk = 1'b0;
    logic          reset;
    logic [NH-1:0] host_req;
    logic [NH-1:0] host_grant;
    logic          host_valid;
    logic [DW-1:0] host_data;
    logic [NH-1:0] host_done;
    logic          dm_enable;
    logic          dm_available;
    logic          dm_read;
    logic          fifo_rdempty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rinc;
    logic          abort;

    always #5 dclk = ~dclk;

    qam_readout_arbiter #(
        .NUM_HOSTS (NH),
        .DATA_W    (DW),
        .BURST_MAX (BM)
    ) dut (
        .dclk         (dclk),
        .reset        (reset),
        .host_req     (host_req),
        .host_grant   (host_grant),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_done    (host_done),
        .dm_enable    (dm_enable),
        .dm_available (dm_available),
        .dm_read      (dm_read),
        .fifo_rdempty (fifo_rdempty),
        .fifo_rdata   (fifo_rdata),
        .fifo_rinc    (fifo_rinc),
        .abort        (abort)
    );

    // FIFO model: the bench writes words, the DUT pops them.
    logic [DW-1:0] fmem [0:255];
    logic [7:0]    f_rd = 8'd0;
    logic [7:0]    f_wr;
    logic          fifo_flush;
    assign fifo_rdempty = (f_rd == f_wr);
    assign fifo_rdata   = fmem[f_rd];
    always @(posedge dclk) begin
        if (fifo_flush)     f_rd <= f_wr;
        else if (fifo_rinc) f_rd <= f_rd + 8'd1;
    end

    // Monitor: records delivered words and counts strobes at each active edge.
    sb_t obs_q[$];
    int  n_dmread = 0;
    int  n_rinc   = 0;
    int  n_abort  = 0;
    int  n_done   = 0;
    always @(posedge dclk) begin
        if (host_valid)  obs_q.push_back({host_grant, host_data});
        if (dm_read)     n_dmread++;
        if (fifo_rinc)   n_rinc++;
        if (abort)       n_abort++;
        if (|host_done)  n_done++;
    end

    sb_t exp_q[$];
    int  obs_i = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  seq = 0;

    task automatic load_word(input logic [NH-1:0] g, input bit expect_out);
        logic [DW-1:0] d;
        d = DW'(seq);
        seq++;
        fmem[f_wr] = d;
        f_wr = f_wr + 8'd1;
        if (expect_out) exp_q.push_back({g, d});
    endtask

    task automatic wait_done(input int budget, output logic [NH-1:0] mask, output bit ok);
        ok = 1'b0;
        mask = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge dclk);
            if (|host_done) begin
                mask = host_done;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rinc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge dclk);
            if (n_rinc >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        host_req = '0;
        dm_available = 1'b0;
        dm_enable = 1'b1;
        repeat (3) @(negedge dclk);
        reset = 1'b0;
        @(negedge dclk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge dclk);
        compared++;
        if ({host_grant, host_valid, host_done, dm_read, fifo_rinc, abort} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got grant=%b valid=%b done=%b rd=%b rinc=%b abort=%b, required all 0",
                     host_grant, host_valid, host_done, dm_read, fifo_rinc, abort);
        end
        reset = 1'b0;
        repeat (4) @(negedge dclk);
        compared++;
        if ({host_grant, host_valid, host_done, dm_read, fifo_rinc, abort} !== '0) begin
            mismatched++;
            $display("FAIL idle_outputs: got grant=%b valid=%b done=%b rd=%b rinc=%b abort=%b, required all 0",
                     host_grant, host_valid, host_done, dm_read, fifo_rinc, abort);
        end
    endtask

    task automatic test_single();
        sb_t e;
        bit ok;
        logic [NH-1:0] mask;
        int b_read, b_rinc, at_done, gcnt;
        b_read = n_dmread;
        b_rinc = n_rinc;
        for (int k = 0; k < 5; k++) load_word(4'b0100, 1'b1);
        host_req = 4'b0100;
        dm_available = 1'b1;
        wait_done(60, mask, ok);
        host_req = '0;
        dm_available = 1'b0;
        at_done = obs_q.size() - obs_i;
        compared++;
        if (!ok || mask !== 4'b0100) begin
            mismatched++;
            $display("FAIL single_done: got ok=%0d mask=%b, required mask=0100", ok, mask);
        end
        compared++;
        if (at_done != 5) begin
            mismatched++;
            $display("FAIL single_words_at_done: got %0d, required 5", at_done);
        end
        repeat (3) @(negedge dclk);
        compared++;
        if (n_dmread - b_read != 1) begin
            mismatched++;
            $display("FAIL single_dm_read: got %0d pulses, required 1", n_dmread - b_read);
        end
        compared++;
        if (n_rinc - b_rinc != 5) begin
            mismatched++;
            $display("FAIL single_pops: got %0d, required 5", n_rinc - b_rinc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_i >= obs_q.size()) begin
                mismatched++;
                $display("FAIL single_sb: got nothing, required grant=%b data=%h", e.grant, e.data);
            end else begin
                if (obs_q[obs_i] !== e) begin
                    mismatched++;
                    $display("FAIL single_sb: got grant=%b data=%h, required grant=%b data=%h",
                             obs_q[obs_i].grant, obs_q[obs_i].data, e.grant, e.data);
                end
                obs_i++;
            end
        end
        compared++;
        if (obs_q.size() != obs_i) begin
            mismatched++;
            $display("FAIL single_extra: got %0d extra words, required 0", obs_q.size() - obs_i);
            obs_i = obs_q.size();
        end
        // With pending clear and no dm_available, a request must not be granted.
        host_req = 4'b0001;
        gcnt = 0;
        repeat (6) begin
            @(negedge dclk);
            if (host_grant != '0) gcnt++;
        end
        host_req = '0;
        compared++;
        if (gcnt != 0) begin
            mismatched++;
            $display("FAIL single_pending: got %0d granted cycles, required 0", gcnt);
        end
    endtask

    task automatic test_round_robin();
        sb_t e;
        bit ok0, ok1, ok2;
        logic [NH-1:0] m0, m1, m2;
        int b_read, b_rinc;
        b_read = n_dmread;
        b_rinc = n_rinc;
        for (int k = 0; k < 16; k++) load_word(4'b0001, 1'b1);
        for (int k = 0; k < 16; k++) load_word(4'b0010, 1'b1);
        for (int k = 0; k < 8; k++)  load_word(4'b1000, 1'b1);
        host_req = 4'b1011;
        dm_available = 1'b1;
        wait_done(80, m0, ok0);
        dm_available = 1'b0;
        wait_done(80, m1, ok1);
        wait_done(80, m2, ok2);
        host_req = '0;
        repeat (3) @(negedge dclk);
        compared++;
        if (!ok0 || m0 !== 4'b0001) begin
            mismatched++;
            $display("FAIL rr_first: got ok=%0d mask=%b, required 0001", ok0, m0);
        end
        compared++;
        if (!ok1 || m1 !== 4'b0010) begin
            mismatched++;
            $display("FAIL rr_second: got ok=%0d mask=%b, required 0010", ok1, m1);
        end
        compared++;
        if (!ok2 || m2 !== 4'b1000) begin
            mismatched++;
            $display("FAIL rr_third: got ok=%0d mask=%b, required 1000", ok2, m2);
        end
        compared++;
        if (n_dmread - b_read != 1) begin
            mismatched++;
            $display("FAIL rr_dm_read: got %0d pulses, required 1", n_dmread - b_read);
        end
        compared++;
        if (n_rinc - b_rinc != 40) begin
            mismatched++;
            $display("FAIL rr_pops: got %0d, required 40", n_rinc - b_rinc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_i >= obs_q.size()) begin
                mismatched++;
                $display("FAIL rr_sb: got nothing, required grant=%b data=%h", e.grant, e.data);
            end else begin
                if (obs_q[obs_i] !== e) begin
                    mismatched++;
                    $display("FAIL rr_sb: got grant=%b data=%h, required grant=%b data=%h",
                             obs_q[obs_i].grant, obs_q[obs_i].data, e.grant, e.data);
                end
                obs_i++;
            end
        end
        compared++;
        if (obs_q.size() != obs_i) begin
            mismatched++;
            $display("FAIL rr_extra: got %0d extra words, required 0", obs_q.size() - obs_i);
            obs_i = obs_q.size();
        end
    endtask

    task automatic test_host_drop();
        sb_t e;
        bit ok, ok1, ok2;
        logic [NH-1:0] m1, m2;
        int b_read, b_rinc;
        b_read = n_dmread;
        b_rinc = n_rinc;
        for (int k = 0; k < 3; k++) load_word(4'b0010, 1'b1);
        for (int k = 0; k < 7; k++) load_word(4'b0100, 1'b1);
        host_req = 4'b0010;
        dm_available = 1'b1;
        wait_rinc(b_rinc + 3, 60, ok);
        host_req = 4'b0100;
        dm_available = 1'b0;
        wait_done(30, m1, ok1);
        wait_done(60, m2, ok2);
        host_req = '0;
        repeat (3) @(negedge dclk);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL drop_three_pops: got %0d pops before timeout, required 3", n_rinc - b_rinc);
        end
        compared++;
        if (!ok1 || m1 !== 4'b0010) begin
            mismatched++;
            $display("FAIL drop_release: got ok=%0d mask=%b, required 0010", ok1, m1);
        end
        compared++;
        if (!ok2 || m2 !== 4'b0100) begin
            mismatched++;
            $display("FAIL drop_pending_grant: got ok=%0d mask=%b, required 0100", ok2, m2);
        end
        compared++;
        if (n_dmread - b_read != 1) begin
            mismatched++;
            $display("FAIL drop_dm_read: got %0d pulses, required 1", n_dmread - b_read);
        end
        compared++;
        if (n_rinc - b_rinc != 10) begin
            mismatched++;
            $display("FAIL drop_pops: got %0d, required 10", n_rinc - b_rinc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_i >= obs_q.size()) begin
                mismatched++;
                $display("FAIL drop_sb: got nothing, required grant=%b data=%h", e.grant, e.data);
            end else begin
                if (obs_q[obs_i] !== e) begin
                    mismatched++;
                    $display("FAIL drop_sb: got grant=%b data=%h, required grant=%b data=%h",
                             obs_q[obs_i].grant, obs_q[obs_i].data, e.grant, e.data);
                end
                obs_i++;
            end
        end
        compared++;
        if (obs_q.size() != obs_i) begin
            mismatched++;
            $display("FAIL drop_extra: got %0d extra words, required 0", obs_q.size() - obs_i);
            obs_i = obs_q.size();
        end
    endtask

    task automatic test_abort();
        sb_t e;
        bit ok, ok2;
        logic [NH-1:0] m;
        int b_read, b_rinc, b_abort, b_done;
        b_read  = n_dmread;
        b_rinc  = n_rinc;
        b_abort = n_abort;
        b_done  = n_done;
        for (int k = 0; k < 2; k++) load_word(4'b0001, 1'b1);
        for (int k = 0; k < 8; k++) load_word(4'b0010, 1'b1);
        host_req = 4'b0001;
        dm_available = 1'b1;
        wait_rinc(b_rinc + 2, 40, ok);
        dm_enable = 1'b0;
        @(negedge dclk);
        compared++;
        if (!ok || abort !== 1'b1 || host_grant !== '0 || host_done !== '0) begin
            mismatched++;
            $display("FAIL abort_pulse: got ok=%0d abort=%b grant=%b done=%b, required abort=1 grant=0000 done=0000",
                     ok, abort, host_grant, host_done);
        end
        @(negedge dclk);
        compared++;
        if (abort !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_width: got abort=%b in second cycle, required 0", abort);
        end
        dm_enable = 1'b1;
        host_req = 4'b0011;
        wait_done(60, m, ok2);
        host_req = '0;
        dm_available = 1'b0;
        repeat (3) @(negedge dclk);
        compared++;
        if (!ok2 || m !== 4'b0010) begin
            mismatched++;
            $display("FAIL abort_rr_ptr: got ok=%0d next burst mask=%b, required 0010", ok2, m);
        end
        compared++;
        if (n_abort - b_abort != 1 || n_done - b_done != 1) begin
            mismatched++;
            $display("FAIL abort_counts: got aborts=%0d dones=%0d, required 1 and 1",
                     n_abort - b_abort, n_done - b_done);
        end
        compared++;
        if (n_dmread - b_read != 2) begin
            mismatched++;
            $display("FAIL abort_dm_read: got %0d pulses, required 2", n_dmread - b_read);
        end
        compared++;
        if (n_rinc - b_rinc != 10) begin
            mismatched++;
            $display("FAIL abort_pops: got %0d, required 10", n_rinc - b_rinc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_i >= obs_q.size()) begin
                mismatched++;
                $display("FAIL abort_sb: got nothing, required grant=%b data=%h", e.grant, e.data);
            end else begin
                if (obs_q[obs_i] !== e) begin
                    mismatched++;
                    $display("FAIL abort_sb: got grant=%b data=%h, required grant=%b data=%h",
                             obs_q[obs_i].grant, obs_q[obs_i].data, e.grant, e.data);
                end
                obs_i++;
            end
        end
        compared++;
        if (obs_q.size() != obs_i) begin
            mismatched++;
            $display("FAIL abort_extra: got %0d extra words, required 0", obs_q.size() - obs_i);
            obs_i = obs_q.size();
        end
    endtask

    task automatic test_reset_mid();
        sb_t e;
        bit ok;
        int b_rinc, b_abort, b_done;
        b_rinc  = n_rinc;
        b_abort = n_abort;
        b_done  = n_done;
        for (int k = 0; k < 2; k++) load_word(4'b1000, 1'b1);
        for (int k = 0; k < 8; k++) load_word(4'b1000, 1'b0);
        host_req = 4'b1000;
        dm_available = 1'b1;
        wait_rinc(b_rinc + 2, 40, ok);
        reset = 1'b1;
        @(negedge dclk);
        compared++;
        if (!ok || {host_grant, host_valid, host_done, dm_read, fifo_rinc, abort} !== '0) begin
            mismatched++;
            $display("FAIL rstmid_outputs: got ok=%0d grant=%b valid=%b done=%b rd=%b rinc=%b abort=%b, required all 0",
                     ok, host_grant, host_valid, host_done, dm_read, fifo_rinc, abort);
        end
        host_req = '0;
        dm_available = 1'b0;
        repeat (2) @(negedge dclk);
        reset = 1'b0;
        fifo_flush = 1'b1;
        @(negedge dclk);
        fifo_flush = 1'b0;
        @(negedge dclk);
        compared++;
        if (n_rinc - b_rinc != 2) begin
            mismatched++;
            $display("FAIL rstmid_pops: got %0d, required 2", n_rinc - b_rinc);
        end
        compared++;
        if (n_abort - b_abort != 0 || n_done - b_done != 0) begin
            mismatched++;
            $display("FAIL rstmid_pulses: got aborts=%0d dones=%0d, required 0 and 0",
                     n_abort - b_abort, n_done - b_done);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_i >= obs_q.size()) begin
                mismatched++;
                $display("FAIL rstmid_sb: got nothing, required grant=%b data=%h", e.grant, e.data);
            end else begin
                if (obs_q[obs_i] !== e) begin
                    mismatched++;
                    $display("FAIL rstmid_sb: got grant=%b data=%h, required grant=%b data=%h",
                             obs_q[obs_i].grant, obs_q[obs_i].data, e.grant, e.data);
                end
                obs_i++;
            end
        end
        compared++;
        if (obs_q.size() != obs_i) begin
            mismatched++;
            $display("FAIL rstmid_extra: got %0d extra words, required 0", obs_q.size() - obs_i);
            obs_i = obs_q.size();
        end
    endtask

    task automatic test_empty_grant();
        bit seen;
        logic [NH-1:0] mask;
        int gcnt, b_read, b_rinc;
        b_read = n_dmread;
        b_rinc = n_rinc;
        seen = 1'b0;
        mask = '0;
        gcnt = 0;
        host_req = 4'b0001;
        dm_available = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge dclk);
            if (host_grant != '0) gcnt++;
            if (|host_done) begin
                mask = host_done;
                host_req = '0;
                dm_available = 1'b0;
            end
            if (gcnt > 0 && host_grant == '0) begin
                seen = 1'b1;
                break;
            end
        end
        host_req = '0;
        dm_available = 1'b0;
        repeat (2) @(negedge dclk);
        compared++;
        if (!seen || gcnt != 3) begin
            mismatched++;
            $display("FAIL empty_grant_cycles: got seen=%0d cycles=%0d, required 3", seen, gcnt);
        end
        compared++;
        if (mask !== 4'b0001) begin
            mismatched++;
            $display("FAIL empty_done: got mask=%b, required 0001", mask);
        end
        compared++;
        if (n_rinc - b_rinc != 0 || n_dmread - b_read != 1) begin
            mismatched++;
            $display("FAIL empty_strobes: got pops=%0d dm_read=%0d, required 0 and 1",
                     n_rinc - b_rinc, n_dmread - b_read);
        end
        compared++;
        if (obs_q.size() != obs_i) begin
            mismatched++;
            $display("FAIL empty_words: got %0d words, required 0", obs_q.size() - obs_i);
            obs_i = obs_q.size();
        end
    endtask

    initial begin
        reset = 1'b1;
        dm_enable = 1'b1;
        dm_available = 1'b0;
        host_req = '0;
        fifo_flush = 1'b0;
        f_wr = 8'd0;
        test_reset();
        test_single();
        apply_reset();
        test_round_robin();
        test_host_drop();
        apply_reset();
        test_abort();
        test_reset_mid();
        test_empty_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
